// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among N_REQ byte sources.
// Define UART_ARB_PRIO0_EN to give requester 0 strict priority at every arbitration point.
module uart_tx_arbiter #(
   parameter int N_REQ     = 4,
   parameter int GW        = 2,
   parameter int MAX_BURST = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   ack,
   output logic [7:0]         tx_data,
   output logic               tx_start,
   input  logic               tx_busy,
   output logic               grant_valid,
   output logic [GW-1:0]      grant_id
);

   localparam int IW = GW + 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [GW-1:0]    ptr_q, ptr_d;
   logic [GW-1:0]    grant_id_q, grant_id_d;
   logic             grant_valid_q, grant_valid_d;
   logic             tx_start_q, tx_start_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic             last_q, last_d;
   logic [7:0]       burst_cnt_q, burst_cnt_d;

   logic [GW-1:0]    win_id;
   logic [GW-1:0]    rel_ptr;
   logic [7:0]       gnt_byte;
   logic             gnt_req;
   logic             gnt_last;
   logic             cap_hit;

   // First asserted request strictly after p, wrapping modulo N_REQ.
   function automatic logic [GW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [GW-1:0]    p);
      logic [GW-1:0] pick;
      logic          found;
      logic [IW-1:0] idx;
      pick  = p;
      found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = {1'b0, p} + IW'(k);
         if (idx >= IW'(N_REQ)) begin
            idx = idx - IW'(N_REQ);
         end
         if (!found && r[idx[GW-1:0]]) begin
            pick  = idx[GW-1:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign gnt_byte = req_data[{grant_id_q, 3'b000} +: 8];
   assign gnt_req  = req[grant_id_q];
   assign gnt_last = req_last[grant_id_q];
   assign cap_hit  = (burst_cnt_q == 8'(MAX_BURST));

`ifdef UART_ARB_PRIO0_EN
   // Requester 0 bypasses rotation and never moves the pointer.
   assign win_id  = req[0] ? '0 : rr_pick(req, ptr_q);
   assign rel_ptr = (grant_id_q == '0) ? ptr_q : grant_id_q;
`else
   assign win_id  = rr_pick(req, ptr_q);
   assign rel_ptr = grant_id_q;
`endif

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      grant_id_d    = grant_id_q;
      grant_valid_d = grant_valid_q;
      tx_data_d     = tx_data_q;
      tx_start_d    = 1'b0;
      ack_d         = '0;
      last_d        = last_q;
      burst_cnt_d   = burst_cnt_q;
      case (state_q)
         IDLE: begin
            if (!tx_busy && (|req)) begin
               grant_id_d    = win_id;
               grant_valid_d = 1'b1;
               burst_cnt_d   = '0;
               state_d       = ISSUE;
            end
         end
         ISSUE: begin
            if (gnt_req) begin
               tx_data_d   = gnt_byte;
               tx_start_d  = 1'b1;
               ack_d       = N_REQ'(1) << grant_id_q;
               last_d      = gnt_last;
               burst_cnt_d = burst_cnt_q + 8'd1;
               state_d     = WAIT_BUSY;
            end else begin
               grant_valid_d = 1'b0;
               ptr_d         = rel_ptr;
               state_d       = IDLE;
            end
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               if (last_q || cap_hit) begin
                  grant_valid_d = 1'b0;
                  ptr_d         = rel_ptr;
                  state_d       = IDLE;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ptr_q         <= GW'(N_REQ - 1);
         grant_id_q    <= '0;
         grant_valid_q <= 1'b0;
         tx_data_q     <= '0;
         tx_start_q    <= 1'b0;
         ack_q         <= '0;
         last_q        <= 1'b0;
         burst_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_id_q    <= grant_id_d;
         grant_valid_q <= grant_valid_d;
         tx_data_q     <= tx_data_d;
         tx_start_q    <= tx_start_d;
         ack_q         <= ack_d;
         last_q        <= last_d;
         burst_cnt_q   <= burst_cnt_d;
      end
   end

   assign ack         = ack_q;
   assign tx_data     = tx_data_q;
   assign tx_start    = tx_start_q;
   assign grant_valid = grant_valid_q;
   assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued requester models, a busy model and a tx_start monitor.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

   localparam int N_REQ     = 4;
   localparam int GW        = 2;
   localparam int MAX_BURST = 16;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [N_REQ-1:0]   req;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_last;
   logic [N_REQ-1:0]   ack;
   logic [7:0]         tx_data;
   logic               tx_start;
   logic               tx_busy;
   logic               grant_valid;
   logic [GW-1:0]      grant_id;

   int errors = 0;
   int checks = 0;

   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [8:0] q2[$];
   logic [8:0] q3[$];
   logic [9:0] exp_q[$];
   int         busy_cnt = 0;
   logic       force_busy = 1'b0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_REQ(N_REQ), .GW(GW), .MAX_BURST(MAX_BURST)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .req_data    (req_data),
      .req_last    (req_last),
      .ack         (ack),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_busy     (tx_busy),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
      end
   endtask

   function automatic void push_byte(input int r, input logic [7:0] d, input logic l);
      case (r)
         0: q0.push_back({l, d});
         1: q1.push_back({l, d});
         2: q2.push_back({l, d});
         default: q3.push_back({l, d});
      endcase
   endfunction

   function automatic void expect_tx(input logic [1:0] id, input logic [7:0] d);
      exp_q.push_back({id, d});
   endfunction

   function automatic int qsize(input int r);
      case (r)
         0: return q0.size();
         1: return q1.size();
         2: return q2.size();
         default: return q3.size();
      endcase
   endfunction

   function automatic logic [8:0] qfront(input int r);
      case (r)
         0: return q0[0];
         1: return q1[0];
         2: return q2[0];
         default: return q3[0];
      endcase
   endfunction

   function automatic void qpop(input int r);
      case (r)
         0: void'(q0.pop_front());
         1: void'(q1.pop_front());
         2: void'(q2.pop_front());
         default: void'(q3.pop_front());
      endcase
   endfunction

   function automatic void clear_all();
      q0.delete();
      q1.delete();
      q2.delete();
      q3.delete();
   endfunction

   function automatic void drive();
      logic [8:0] f;
      req      = '0;
      req_data = '0;
      req_last = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (qsize(i) > 0) begin
            f                  = qfront(i);
            req[i]             = 1'b1;
            req_data[8*i +: 8] = f[7:0];
            req_last[i]        = f[8];
         end
      end
   endfunction

   // One clock: consume acked bytes, advance the transmitter busy model.
   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++) begin
         if (ack[i]) qpop(i);
      end
      if (tx_start) busy_cnt = 10;
      else if (busy_cnt > 0) busy_cnt--;
      tx_busy = force_busy || (busy_cnt > 0);
      drive();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_all();
      busy_cnt   = 0;
      force_busy = 1'b0;
      tx_busy    = 1'b0;
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_done(input string name, input int bound);
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && !grant_valid && !tx_busy) && n < bound) begin
         step();
         n++;
      end
      check({name, "_complete"}, 32'(n < bound), 1);
   endtask

   task automatic wait_gv(input logic v, input string name);
      int n;
      n = 0;
      while (grant_valid !== v && n < 200) begin
         step();
         n++;
      end
      check({name, "_gv_wait"}, 32'(n < 200), 1);
   endtask

   task automatic wait_start(input string name);
      int n;
      n = 0;
      while (tx_start !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      check({name, "_start_wait"}, 32'(n < 200), 1);
   endtask

   initial begin : monitor
      int         since;
      logic [9:0] e;
      since = 100;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            since = 100;
         end else begin
            since++;
            if (tx_start) begin
               check("start_spacing", 32'(since >= 3), 1);
               since = 0;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_start: got id=%0d data=0x%0h expected no tx_start", grant_id, tx_data);
               end else begin
                  e = exp_q.pop_front();
                  check("tx_grant_id", 32'(grant_id), 32'(e[9:8]));
                  check("tx_data", 32'(tx_data), 32'(e[7:0]));
                  check("ack_onehot", 32'(ack), 32'(4'b0001 << e[9:8]));
                  check("gv_at_start", 32'(grant_valid), 1);
               end
            end else begin
               check("ack_without_start", 32'(ack), 0);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin : stim
      req      = '0;
      req_data = '0;
      req_last = '0;
      tx_busy  = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", 32'(ack), 0);
      check("rst_tx_data", 32'(tx_data), 0);
      check("rst_tx_start", 32'(tx_start), 0);
      check("rst_gv", 32'(grant_valid), 0);
      check("rst_gid", 32'(grant_id), 0);
      rst_n = 1'b1;
      step();
      check("idle_no_grant", 32'(grant_valid), 0);

      // Single requester, two-byte burst
      push_byte(1, 8'h55, 1'b0);
      push_byte(1, 8'hA3, 1'b1);
      expect_tx(2'd1, 8'h55);
      expect_tx(2'd1, 8'hA3);
      drive();
      wait_done("t1", 400);

      // Back-to-back single-byte bursts: one idle cycle then re-grant
      push_byte(1, 8'h61, 1'b1);
      push_byte(1, 8'h62, 1'b1);
      expect_tx(2'd1, 8'h61);
      expect_tx(2'd1, 8'h62);
      drive();
      wait_gv(1'b1, "t1b_up");
      wait_gv(1'b0, "t1b_down");
      step();
      check("regrant_gv", 32'(grant_valid), 1);
      check("regrant_gid", 32'(grant_id), 1);
      wait_done("t1b", 400);

      // All four requesting: rotation 0,1,2,3,0
      do_reset();
      push_byte(0, 8'h10, 1'b1);
      push_byte(1, 8'h11, 1'b1);
      push_byte(2, 8'h12, 1'b1);
      push_byte(3, 8'h13, 1'b1);
      push_byte(0, 8'h20, 1'b1);
      expect_tx(2'd0, 8'h10);
      expect_tx(2'd1, 8'h11);
      expect_tx(2'd2, 8'h12);
      expect_tx(2'd3, 8'h13);
      expect_tx(2'd0, 8'h20);
      drive();
      wait_done("t2", 800);

      // Burst cap: requester 2 streams 20 bytes, requester 3 cuts in after the cap
      do_reset();
      for (int k = 0; k < 20; k++) push_byte(2, 8'(8'h80 + k), 1'b0);
      push_byte(3, 8'hC3, 1'b1);
      for (int k = 0; k < MAX_BURST; k++) expect_tx(2'd2, 8'(8'h80 + k));
      expect_tx(2'd3, 8'hC3);
      for (int k = MAX_BURST; k < 20; k++) expect_tx(2'd2, 8'(8'h80 + k));
      drive();
      wait_done("t3", 1500);

      // Requester 0 withdraws while in ISSUE
      do_reset();
      push_byte(0, 8'h77, 1'b1);
      drive();
      wait_gv(1'b1, "t4_up");
      q0.delete();
      drive();
      step();
      check("withdraw_gv", 32'(grant_valid), 0);
      check("withdraw_start", 32'(tx_start), 0);
      check("withdraw_ack", 32'(ack), 0);
      push_byte(0, 8'h78, 1'b1);
      push_byte(1, 8'h79, 1'b1);
`ifdef UART_ARB_PRIO0_EN
      expect_tx(2'd0, 8'h78);
      expect_tx(2'd1, 8'h79);
`else
      expect_tx(2'd1, 8'h79);
      expect_tx(2'd0, 8'h78);
`endif
      drive();
      wait_done("t4", 400);

      // tx_busy held across reset release blocks the grant
      rst_n = 1'b0;
      clear_all();
      busy_cnt   = 0;
      force_busy = 1'b1;
      tx_busy    = 1'b1;
      push_byte(1, 8'h31, 1'b1);
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check("busy_no_grant", 32'(grant_valid), 0);
      end
      force_busy = 1'b0;
      expect_tx(2'd1, 8'h31);
      wait_done("t5a", 400);

      // Reset pulsed while in WAIT_DONE
      push_byte(2, 8'h51, 1'b0);
      push_byte(2, 8'h52, 1'b1);
      expect_tx(2'd2, 8'h51);
      drive();
      wait_start("t5b");
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      check("midrst_ack", 32'(ack), 0);
      check("midrst_tx_data", 32'(tx_data), 0);
      check("midrst_tx_start", 32'(tx_start), 0);
      check("midrst_gv", 32'(grant_valid), 0);
      check("midrst_gid", 32'(grant_id), 0);
      clear_all();
      busy_cnt = 0;
      tx_busy  = 1'b0;
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check("post_rst_ack", 32'(ack), 0);
         check("post_rst_start", 32'(tx_start), 0);
      end

      // Priority scenario: requesters 0 and 1 pending after a requester-0 burst
      do_reset();
      push_byte(0, 8'hE0, 1'b1);
      expect_tx(2'd0, 8'hE0);
      drive();
      wait_done("t6a", 400);
      push_byte(0, 8'hE1, 1'b1);
      push_byte(1, 8'hE2, 1'b1);
`ifdef UART_ARB_PRIO0_EN
      expect_tx(2'd0, 8'hE1);
      expect_tx(2'd1, 8'hE2);
`else
      expect_tx(2'd1, 8'hE2);
      expect_tx(2'd0, 8'hE1);
`endif
      drive();
      wait_done("t6", 400);

      repeat (3) step();
      check("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
